ddr_test_data_gen: RTL

Test-pattern source for the DDR2 memory test path. On a start pulse it writes a burst of BURST_LEN 32-bit words into the memory write FIFO under backpressure. It then replays the identical sequence as expected data, one word per read-back beat, for the downstream data comparator. Its expected-data outputs are timed to match the comparator's one-cycle registered read-data path.

---
 rtl/ddr_test_pkg.sv | 26 ++
 rtl/ddr_test_data_gen_if.sv | 23 ++
 rtl/ddr_test_pattern.sv | 21 ++
 rtl/ddr_test_data_gen.sv | 105 ++++++++++
 4 files changed

// File: rtl/ddr_test_pkg.sv
// Shared types and pattern math for the DDR2 test data generator.
// Build option: DDR_TEST_LFSR_EN selects the Galois LFSR pattern instead of the incrementing counter.
package ddr_test_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    function automatic logic [31:0] pattern_next(input logic [31:0] w);
`ifdef DDR_TEST_LFSR_EN
        return (w >> 1) ^ (w[0] ? LFSR_MASK : 32'h0);
`else
        return w + 32'd1;
`endif
    endfunction

    // An all-zero LFSR state would lock up, so a zero seed becomes 1.
    function automatic logic [31:0] pattern_seed(input logic [31:0] s);
`ifdef DDR_TEST_LFSR_EN
        return (s == 32'h0) ? 32'h1 : s;
`else
        return s;
`endif
    endfunction

endpackage

// File: rtl/ddr_test_data_gen_if.sv
// Handshake and data bus between the test data generator and the memory test path.
interface ddr_test_data_gen_if;
    logic        start;
    logic        wr_full;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_start;
    logic        rd_vd;
    logic [31:0] exp_data;
    logic        exp_vd;
    logic        busy;
    logic        done;

    modport master (
        input  start, wr_full, rd_vd,
        output wr_en, wr_data, rd_start, exp_data, exp_vd, busy, done
    );

    modport slave (
        output start, wr_full, rd_vd,
        input  wr_en, wr_data, rd_start, exp_data, exp_vd, busy, done
    );
endinterface

// File: rtl/ddr_test_pattern.sv
// One 32-bit pattern generator: reloads the seed word on load, steps on adv.
module ddr_test_pattern
    import ddr_test_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        load,
    input  logic        adv,
    output logic [31:0] word
);

    always_ff @(posedge sys_clk) begin
        if (reset || load)
            word <= pattern_seed(SEED);
        else if (adv)
            word <= pattern_next(word);
    end

endmodule

// File: rtl/ddr_test_data_gen.sv
// Writes a BURST_LEN-word pattern into the write FIFO, then replays it as expected data per read beat.
// Build option: DDR_TEST_LFSR_EN (LFSR pattern instead of incrementing words).
module ddr_test_data_gen
    import ddr_test_pkg::*;
#(
    parameter int          BURST_LEN = 256,
    parameter logic [31:0] SEED      = 32'h0000_0001
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    ddr_test_data_gen_if.master  bus
);

    localparam int             CW   = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0]  LEN  = CW'(BURST_LEN);
    localparam logic [CW-1:0]  LAST = CW'(BURST_LEN - 1);

    state_t        state;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic [31:0]   wr_word, exp_word;
    logic          load, wr_adv, rd_adv;

    logic          wr_en_q, rd_start_q, exp_vd_q, busy_q, done_q;
    logic [31:0]   wr_data_q, exp_data_q;

    assign load   = (state == IDLE) && bus.start;
    assign wr_adv = (state == WRITE) && !bus.wr_full && (wr_cnt < LEN);
    assign rd_adv = (state == READ) && bus.rd_vd;

    ddr_test_pattern #(.SEED(SEED)) u_wr_gen (
        .sys_clk (sys_clk),
        .reset   (reset),
        .load    (load),
        .adv     (wr_adv),
        .word    (wr_word)
    );

    ddr_test_pattern #(.SEED(SEED)) u_exp_gen (
        .sys_clk (sys_clk),
        .reset   (reset),
        .load    (load),
        .adv     (rd_adv),
        .word    (exp_word)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            rd_start_q <= 1'b0;
            exp_vd_q   <= 1'b0;
            exp_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_en_q    <= 1'b0;
            rd_start_q <= 1'b0;
            exp_vd_q   <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state  <= WRITE;
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                    busy_q <= 1'b1;
                end
                WRITE: if (wr_adv) begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= wr_word;
                    wr_cnt    <= wr_cnt + CW'(1);
                    if (wr_cnt == LAST) begin
                        state      <= READ;
                        rd_start_q <= 1'b1;
                    end
                end
                // Expected word lands one cycle after rd_vd, aligned with the comparator's registered read data.
                READ: if (rd_adv) begin
                    exp_vd_q   <= 1'b1;
                    exp_data_q <= exp_word;
                    rd_cnt     <= rd_cnt + CW'(1);
                    if (rd_cnt == LAST)
                        state <= DONE;
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_start = rd_start_q;
    assign bus.exp_vd   = exp_vd_q;
    assign bus.exp_data = exp_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
